// File: rtl/mux4_scan_if.sv
// mux4_scan_if: bundles the signals between the scan sequencer and its
// surroundings: the mux select/output pair and the result handshake.
//   start   : scan request into the sequencer
//   s1, s2  : mux select MSB/LSB out of the sequencer
//   mux_out : mux output into the sequencer
//   word    : 4-bit scan result, bit k = channel k sample
//   valid   : word holds a new, unconsumed result
//   ready   : consumer accepts word
//   busy    : sequencer is not idle
// master = sequencer side, slave = mux/consumer side.
interface mux4_scan_if;
  logic       start;
  logic       s1;
  logic       s2;
  logic       mux_out;
  logic [3:0] word;
  logic       valid;
  logic       ready;
  logic       busy;

  modport master (
    input  start, mux_out, ready,
    output s1, s2, word, valid, busy
  );

  modport slave (
    output start, mux_out, ready,
    input  s1, s2, word, valid, busy
  );
endinterface

// File: rtl/mux4_scan_seq.sv
// mux4_scan_seq: steps a 4:1 mux through channels 0..3, holds each select
// for SETTLE cycles, samples the mux output on the last cycle and offers the
// four samples as one word on a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mux4_scan_if.master (start, s1, s2, mux_out, word, valid, ready, busy)
// Parameter:
//   SETTLE : cycles each select value is held before sampling (1..15)
// Optional feature macro:
//   MUX4_SCAN_CONT_EN : when defined, a completed handshake immediately
//                       starts the next scan instead of returning to idle.
module mux4_scan_seq #(
  parameter int unsigned SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  mux4_scan_if.master    bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 4;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          sel;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   shd;
  logic [WORD_W-1:0]   shd_cap;
  logic [WORD_W-1:0]   word_q;
  logic                valid_q;
  logic                busy_q;

  // Shadow with the current channel's sample merged in, so the last channel
  // lands in word on the same edge it is captured.
  always_comb begin
    shd_cap      = shd;
    shd_cap[sel] = bus.mux_out;
  end

  assign bus.s1    = sel[1];
  assign bus.s2    = sel[0];
  assign bus.word  = word_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

  // Scan FSM with all outputs held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sel     <= 2'd0;
      cnt     <= '0;
      shd     <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sel    <= 2'd0;
            cnt    <= RELOAD;
            shd    <= '0;
            busy_q <= 1'b1;
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shd <= shd_cap;
            if (sel != 2'd3) begin
              sel <= sel + 2'd1;
              cnt <= RELOAD;
            end else begin
              word_q  <= shd_cap;
              valid_q <= 1'b1;
              state   <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (valid_q && bus.ready) begin
            valid_q <= 1'b0;
            sel     <= 2'd0;
`ifdef MUX4_SCAN_CONT_EN
            // Continuous mode: rearm immediately, busy stays high.
            cnt     <= RELOAD;
            shd     <= '0;
            state   <= S_WAIT;
`else
            busy_q  <= 1'b0;
            state   <= S_IDLE;
`endif
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_scan_seq.sv
// tb_mux4_scan_seq: two sequencers (SETTLE=2 and SETTLE=1) each wrapped
// around a behavioural 4:1 mux whose inputs change randomly every cycle.
// Expected selects, valid timing and result words are derived from the
// edge-count timing rules of the scan.
module tb_mux4_scan_seq;

`ifdef MUX4_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_v [2];
  logic       ready_v [2];
  logic [3:0] data_v  [2];

  logic [1:0] sel_o   [2];
  logic       valid_o [2];
  logic       busy_o  [2];
  logic [3:0] word_o  [2];

  int n_tests = 0;
  int n_fail  = 0;

  mux4_scan_if if0 ();
  mux4_scan_if if1 ();

  mux4_scan_seq #(.SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  mux4_scan_seq #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  // Behavioural mux4_1 plus stimulus wiring.
  assign if0.start   = start_v[0];
  assign if0.ready   = ready_v[0];
  assign if0.mux_out = data_v[0][{if0.s1, if0.s2}];
  assign if1.start   = start_v[1];
  assign if1.ready   = ready_v[1];
  assign if1.mux_out = data_v[1][{if1.s1, if1.s2}];

  assign sel_o[0]   = {if0.s1, if0.s2};
  assign sel_o[1]   = {if1.s1, if1.s2};
  assign valid_o[0] = if0.valid;
  assign valid_o[1] = if1.valid;
  assign busy_o[0]  = if0.busy;
  assign busy_o[1]  = if1.busy;
  assign word_o[0]  = if0.word;
  assign word_o[1]  = if1.word;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One scan on sequencer d with settle s. chained=1 means the previous
  // handshake edge already acted as E0 (continuous mode).
  task automatic run_scan(input int d, input int s, input int bp,
                          input bit mid_start, input bit chained);
    logic [3:0] exp;
    int         k;
    exp = 4'h0;
    if (!chained) begin
      @(negedge clk);
      start_v[d] = 1'b1;
      ready_v[d] = (bp == 0);
      data_v[d]  = 4'($urandom);
      @(posedge clk); #1;
      check("e0_sel",   32'(sel_o[d]),   0);
      check("e0_busy",  32'(busy_o[d]),  1);
      check("e0_valid", 32'(valid_o[d]), 0);
    end
    for (int t = 1; t <= 4 * s; t++) begin
      @(negedge clk);
      start_v[d] = (mid_start && t == 3);
      data_v[d]  = 4'($urandom);
      // Channel k is sampled at edge (k+1)*s with whatever the mux shows then.
      if (t % s == 0) begin
        k = t / s - 1;
        exp[k] = data_v[d][k];
      end
      @(posedge clk); #1;
      check("scan_sel",   32'(sel_o[d]),   (t < 4 * s) ? 32'(t / s) : 3);
      check("scan_valid", 32'(valid_o[d]), (t == 4 * s) ? 1 : 0);
      check("scan_busy",  32'(busy_o[d]),  1);
    end
    check("scan_word", 32'(word_o[d]), 32'(exp));
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      ready_v[d] = 1'b0;
      start_v[d] = (b == 1);
      @(posedge clk); #1;
      check("bp_valid", 32'(valid_o[d]), 1);
      check("bp_word",  32'(word_o[d]),  32'(exp));
      check("bp_busy",  32'(busy_o[d]),  1);
    end
    @(negedge clk);
    ready_v[d] = 1'b1;
    start_v[d] = 1'b0;
    @(posedge clk); #1;
    check("hs_valid", 32'(valid_o[d]), 0);
    check("hs_busy",  32'(busy_o[d]),  32'(CONT));
    check("hs_word",  32'(word_o[d]),  32'(exp));
    check("hs_sel",   32'(sel_o[d]),   0);
  endtask

  // Reset asserted while channel 2 is selected; no valid may follow.
  task automatic reset_mid_scan(input int d, input int s);
    @(negedge clk);
    start_v[d] = 1'b1;
    ready_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int t = 1; t < 2 * s; t++) @(posedge clk);
    @(posedge clk); #1;
    check("rm_sel2", 32'(sel_o[d]), 2);
    #2;
    rst = 1'b1;
    #1;
    check("rm_sel",   32'(sel_o[d]),   0);
    check("rm_valid", 32'(valid_o[d]), 0);
    check("rm_busy",  32'(busy_o[d]),  0);
    check("rm_word",  32'(word_o[d]),  0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4 * s + 2; t++) begin
      @(posedge clk); #1;
      check("rm_quiet_valid", 32'(valid_o[d]), 0);
      check("rm_quiet_busy",  32'(busy_o[d]),  0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      ready_v[i] = 1'b1;
      data_v[i]  = 4'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_sel",   32'(sel_o[i]),   0);
      check("rst_valid", 32'(valid_o[i]), 0);
      check("rst_busy",  32'(busy_o[i]),  0);
      check("rst_word",  32'(word_o[i]),  0);
    end
    @(negedge clk);
    rst = 1'b0;

    if (!CONT) begin
      repeat (3) run_scan(0, 2, 0, 1'b0, 1'b0);
      run_scan(0, 2, 5, 1'b0, 1'b0);
      run_scan(0, 2, 0, 1'b1, 1'b0);
      repeat (3) run_scan(1, 1, 0, 1'b0, 1'b0);
      run_scan(1, 1, 3, 1'b1, 1'b0);
      reset_mid_scan(0, 2);
      run_scan(0, 2, 0, 1'b0, 1'b0);
      reset_mid_scan(1, 1);
      run_scan(1, 1, 0, 1'b0, 1'b0);
    end else begin
      run_scan(0, 2, 0, 1'b0, 1'b0);
      repeat (4) run_scan(0, 2, 0, 1'b0, 1'b1);
      run_scan(1, 1, 0, 1'b0, 1'b0);
      repeat (4) run_scan(1, 1, 0, 1'b0, 1'b1);
      reset_mid_scan(0, 2);
      run_scan(0, 2, 0, 1'b0, 1'b0);
      run_scan(0, 2, 0, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_scan_seq.md
# mux4_scan_seq

Sequencer that drives the two select lines of the 4:1 gate-level multiplexer (`mux4_1`) and consumes its output. On a start request it steps the selects through channels 0–3, waits a programmable settle time on each, and samples the mux output. It then presents the four samples as one 4-bit word on a valid/ready handshake. It sits directly around the mux: upstream of its select inputs and downstream of its `out`.

## Interface

**Parameters**
- `SETTLE`, default 2: cycles each select value is held before its sample is taken. Legal range 1..15.

**Ports**
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — scan request; sampled only in IDLE.
- `s1`  out  1  — mux select MSB; drives `mux4_1.s1`.
- `s2`  out  1  — mux select LSB; drives `mux4_1.s2`.
- `mux_out`  in  1  — mux output (`mux4_1.out`).
- `word`  out  4  — scan result; bit k is the sample of channel k.
- `valid`  out  1  — `word` holds a new, unconsumed result.
- `ready`  in  1  — consumer accepts `word`.
- `busy`  out  1  — high in any state other than IDLE.

## Operation

- Internal state:
  - `sel[1:0]`, with `s1 = sel[1]` and `s2 = sel[0]`. Channel k is therefore selected when `{s1,s2} = k`.
  - 4-bit settle counter `cnt`.
  - 4-bit shadow register `shd`.
- FSM states: IDLE, WAIT, DONE.
- **IDLE**:
  - If `start` = 1: set `sel`=0, set `cnt`=SETTLE-1, clear `shd`, go to WAIT.
  - Otherwise remain in IDLE.
- **WAIT**:
  - If `cnt` ≠ 0: decrement `cnt`.
  - If `cnt` = 0: capture `mux_out` into `shd[sel]`.
    - If `sel` < 3: increment `sel`, reload `cnt`=SETTLE-1, stay in WAIT.
    - If `sel` = 3: load `word` with `shd`, including the bit captured on this same edge. Set `valid`=1 and go to DONE. `sel` holds at 3.
- **DONE**:
  - Hold `valid`=1 and keep `word` stable until `ready`=1.
  - On `valid & ready`: clear `valid`, set `sel`=0, go to IDLE (see Configuration).
- `start` is ignored in WAIT and DONE; no queuing.
- `word` retains the last result after the handshake until the next scan completes.
- **Reset values** (asynchronous, taken immediately on `rst` = 1): state IDLE, `sel`=0 (`s1`=`s2`=0), `cnt`=0, `shd`=0, `word`=0, `valid`=0, `busy`=0.
- **Reset mid-scan**: the partial scan is discarded, no `valid` pulse is produced, and outputs return to their reset values.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- Edge numbering: E0 is the edge that accepts `start`. From E0, `s1`/`s2` = channel 0 and `busy` = 1.
- Channel k is captured at edge E0 + (k+1)·SETTLE.
- The select advances on the same edge as the capture. Each channel is therefore presented for exactly SETTLE cycles before its capture edge.
- `valid` rises at E0 + 4·SETTLE.
- With `ready` already high, the handshake completes on the next edge, E0 + 4·SETTLE + 1. `busy` drops on that edge.
- Earliest following start: a new `start` can be accepted at E0 + 4·SETTLE + 2.

## Configuration

- **`MUX4_SCAN_CONT_EN`**
  - Defined (continuous mode): on `valid & ready` in DONE, the FSM goes straight to WAIT with `sel`=0, `cnt`=SETTLE-1 and `shd` cleared, so `busy` stays high. `start` is needed only to leave IDLE the first time. Only `rst` returns the FSM to IDLE.
  - Not defined: after each handshake the FSM returns to IDLE and waits for a new `start`.

## Test plan

- **Basic scan**: SETTLE=2, mux inputs i0..i3 = 1,0,1,0, pulse `start` → `{s1,s2}` steps 00, 01, 10, 11 for 2 cycles each. `valid` rises at E0+8 with `word` = 4'b0101.
- **Backpressure**: same setup, `ready` held low for 5 cycles → `valid` stays 1 and `word` stays 0101. A `start` pulse during DONE is ignored. Raising `ready` → `valid` drops next edge and `busy` drops.
- **Minimum settle**: SETTLE=1, inputs 0,1,1,0 → `valid` at E0+4 with `word` = 4'b0110.
- **Reset mid-scan**: assert `rst` while `sel`=2 → `s1`=`s2`=0, `valid`=0, `busy`=0, `word`=0 immediately, with no `valid` pulse afterwards. A new `start` then gives a correct full scan.
- **Start while busy**: pulse `start` at E0+3 → no restart; the scan completes at E0+8 with the correct word.
- **`MUX4_SCAN_CONT_EN` defined**: `ready` tied high, inputs 1,1,0,0 → `valid` pulses every 4·SETTLE+1 cycles with `word` = 4'b0011, and `busy` never drops.
